dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-cycle data memory.
// Combinational grant, optional per-port lock, registered read return per port.
module dmem_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int LOCK_EN   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        lock0,
  input  logic        lock1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic        mem_wrEnable,
  output logic        mem_rdEnable,
  output logic [4:0]  mem_wrAddress,
  output logic [4:0]  mem_rdAddress,
  output logic [31:0] mem_wrData,
  input  logic [31:0] mem_rdData
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_last;          // port granted most recently (1 => port 0 wins next tie)
  logic        r_rvalid0, r_rvalid1;
  logic [31:0] r_rdata0, r_rdata1;

  logic        w_gnt0, w_gnt1, w_any, w_sel, w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_wdata;
  logic        w_rd0, w_rd1;

  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          if (PRIO_MODE != 0 || r_last) w_gnt0 = 1'b1;
          else                          w_gnt1 = 1'b1;
        end else begin
          w_gnt0 = req0;
          w_gnt1 = req1;
        end
        if (LOCK_EN != 0) begin
          if (w_gnt0 && lock0)      w_state_nxt = LOCK0;
          else if (w_gnt1 && lock1) w_state_nxt = LOCK1;
        end
      end
      // Owner may idle under lock; the other port stalls until lock drops.
      LOCK0: begin
        w_gnt0 = req0;
        if (!lock0) w_state_nxt = IDLE;
      end
      LOCK1: begin
        w_gnt1 = req1;
        if (!lock1) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Reset must silence the combinational outputs immediately, not at the next edge.
    if (rst) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  assign w_any   = w_gnt0 | w_gnt1;
  assign w_sel   = w_gnt1;
  assign w_we    = w_sel ? we1    : we0;
  assign w_addr  = w_sel ? addr1  : addr0;
  assign w_wdata = w_sel ? wdata1 : wdata0;
  assign w_rd0   = w_gnt0 & ~we0;
  assign w_rd1   = w_gnt1 & ~we1;

  assign gnt0          = w_gnt0;
  assign gnt1          = w_gnt1;
  assign mem_wrEnable  = w_any & w_we;
  assign mem_rdEnable  = w_any & ~w_we;
  assign mem_wrAddress = mem_wrEnable ? w_addr  : 5'd0;
  assign mem_wrData    = mem_wrEnable ? w_wdata : 32'd0;
  assign mem_rdAddress = mem_rdEnable ? w_addr  : 5'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= 32'd0;
      r_rdata1  <= 32'd0;
    end else begin
      r_state   <= w_state_nxt;
      if (w_any) r_last <= w_sel;
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) r_rdata0 <= mem_rdData;
      if (w_rd1) r_rdata1 <= mem_rdData;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: instance 0 is round-robin with locks, instance 1 fixed priority without locks.
module tb_dmem_arbiter;
  typedef struct {
    int          g;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wd;
  } exp_t;
  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] d0;
    logic [31:0] d1;
  } rd_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rq, wq, lq;
  logic [4:0]  aq [2];
  logic [31:0] dq [2];

  logic        g0_o [2], g1_o [2], rv0_o [2], rv1_o [2], mwe_o [2], mre_o [2];
  logic [31:0] rd0_o [2], rd1_o [2], mwd_o [2], mrdd [2];
  logic [4:0]  mwa_o [2], mra_o [2];

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  exp_t qg0[$], qg1[$];
  rd_t  qr0[$], qr1[$];

  // reference model state
  int          own [2];
  int          lst [2];
  int          gv  [2];
  logic [31:0] mmem [2][32];
  logic [31:0] mrd  [2][2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] tmem [32];
    dmem_arbiter #(.PRIO_MODE(k), .LOCK_EN(1 - k)) u_dut (
      .clk(clk), .rst(rst),
      .req0(rq[0]), .req1(rq[1]), .we0(wq[0]), .we1(wq[1]),
      .lock0(lq[0]), .lock1(lq[1]),
      .addr0(aq[0]), .addr1(aq[1]), .wdata0(dq[0]), .wdata1(dq[1]),
      .gnt0(g0_o[k]), .gnt1(g1_o[k]),
      .rdata0(rd0_o[k]), .rdata1(rd1_o[k]),
      .rvalid0(rv0_o[k]), .rvalid1(rv1_o[k]),
      .mem_wrEnable(mwe_o[k]), .mem_rdEnable(mre_o[k]),
      .mem_wrAddress(mwa_o[k]), .mem_rdAddress(mra_o[k]),
      .mem_wrData(mwd_o[k]), .mem_rdData(mrdd[k])
    );
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int a = 0; a < 32; a++) tmem[a] <= 32'(a * 7 + 1);
      end else if (mwe_o[k]) begin
        tmem[mwa_o[k]] <= mwd_o[k];
      end
    end
    assign mrdd[k] = mre_o[k] ? tmem[mra_o[k]] : 32'd0;
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = -1;
      lst[k] = 1;
      gv[k]  = -1;
      mrd[k][0] = 32'd0;
      mrd[k][1] = 32'd0;
      for (int a = 0; a < 32; a++) mmem[k][a] = 32'(a * 7 + 1);
    end
  endtask

  // One cycle of the arbitration rules for each instance; pushes expectations.
  task automatic step();
    exp_t e;
    rd_t  r;
    int   g;
    for (int k = 0; k < 2; k++) begin
      g = -1;
      if (own[k] >= 0) begin
        if (rq[own[k]]) g = own[k];
      end else if (rq[0] && rq[1]) begin
        g = (k == 1) ? 0 : 1 - lst[k];
      end else if (rq[0]) begin
        g = 0;
      end else if (rq[1]) begin
        g = 1;
      end
      e.g = g;
      e.we = 1'b0; e.addr = 5'd0; e.wd = 32'd0;
      if (g >= 0) begin
        e.we = wq[g]; e.addr = aq[g]; e.wd = dq[g];
        lst[k] = g;
        if (wq[g]) begin
          mmem[k][aq[g]] = dq[g];
        end else begin
          mrd[k][g] = mmem[k][aq[g]];
          r.cyc = cyc + 1; r.port = g; r.d0 = mrd[k][0]; r.d1 = mrd[k][1];
          if (k == 0) qr0.push_back(r); else qr1.push_back(r);
        end
      end
      if (own[k] >= 0) begin
        if (!lq[own[k]]) own[k] = -1;
      end else if (g >= 0 && lq[g] && k == 0) begin
        own[k] = g;
      end
      gv[k] = g;
      if (k == 0) qg0.push_back(e); else qg1.push_back(e);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic l0, input logic [4:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic l1,
                       input logic [4:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rq = {r1, r0}; wq = {w1, w0}; lq = {l1, l0};
    aq[0] = a0; aq[1] = a1; dq[0] = d0; dq[1] = d1;
    step();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic chk_reset(input string nm);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({g0_o[k], g1_o[k], rv0_o[k], rv1_o[k], mwe_o[k], mre_o[k]} !== 6'd0 ||
          rd0_o[k] !== 32'd0 || rd1_o[k] !== 32'd0 ||
          mwa_o[k] !== 5'd0 || mra_o[k] !== 5'd0 || mwd_o[k] !== 32'd0) begin
        errors++;
        $display("FAIL %s inst%0d: gnt=%b%b rvalid=%b%b rdata=%h/%h wr=%b rd=%b want all zero",
                 nm, k, g1_o[k], g0_o[k], rv1_o[k], rv0_o[k], rd1_o[k], rd0_o[k], mwe_o[k], mre_o[k]);
      end
    end
  endtask

  task automatic async_reset();
    #6;
    rst = 1'b1;
    #1;
    chk_reset("rst_async");
    qg0.delete(); qg1.delete(); qr0.delete(); qr1.delete();
    model_reset();
    rq = 2'b00; wq = 2'b00; lq = 2'b00;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic check_g(input int k, input exp_t e);
    logic [1:0]  eg;
    logic        ewe, ere;
    logic [4:0]  ewa, era;
    logic [31:0] ewd;
    eg  = (e.g == 0) ? 2'b01 : (e.g == 1) ? 2'b10 : 2'b00;
    ewe = (e.g >= 0) && e.we;
    ere = (e.g >= 0) && !e.we;
    ewa = ewe ? e.addr : 5'd0;
    ewd = ewe ? e.wd : 32'd0;
    era = ere ? e.addr : 5'd0;
    checks++;
    if ({g1_o[k], g0_o[k]} !== eg) begin
      errors++;
      $display("FAIL gnt inst%0d cyc%0d: got %b want %b", k, cyc, {g1_o[k], g0_o[k]}, eg);
    end
    checks++;
    if ({mwe_o[k], mre_o[k], mwa_o[k], mra_o[k], mwd_o[k]} !== {ewe, ere, ewa, era, ewd}) begin
      errors++;
      $display("FAIL mem inst%0d cyc%0d: got we=%b re=%b wa=%0d ra=%0d wd=%h want we=%b re=%b wa=%0d ra=%0d wd=%h",
               k, cyc, mwe_o[k], mre_o[k], mwa_o[k], mra_o[k], mwd_o[k], ewe, ere, ewa, era, ewd);
    end
  endtask

  task automatic check_r(input int k, input logic have, input rd_t r);
    logic [1:0] ev;
    ev = have ? ((r.port == 0) ? 2'b01 : 2'b10) : 2'b00;
    checks++;
    if ({rv1_o[k], rv0_o[k]} !== ev) begin
      errors++;
      $display("FAIL rvalid inst%0d cyc%0d: got %b want %b", k, cyc, {rv1_o[k], rv0_o[k]}, ev);
    end
    if (have) begin
      checks++;
      if (rd0_o[k] !== r.d0 || rd1_o[k] !== r.d1) begin
        errors++;
        $display("FAIL rdata inst%0d cyc%0d: got %h/%h want %h/%h", k, cyc, rd0_o[k], rd1_o[k], r.d0, r.d1);
      end
    end
  endtask

  // Monitor: mid-cycle, compare whatever the DUTs present against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        exp_t e;
        rd_t  r;
        logic have;
        have = 1'b0;
        if (k == 0 && qg0.size() > 0) begin e = qg0.pop_front(); have = 1'b1; end
        if (k == 1 && qg1.size() > 0) begin e = qg1.pop_front(); have = 1'b1; end
        if (have) check_g(k, e);
        have = 1'b0;
        r.cyc = 0; r.port = 0; r.d0 = 32'd0; r.d1 = 32'd0;
        if (k == 0 && qr0.size() > 0 && qr0[0].cyc == cyc) begin r = qr0.pop_front(); have = 1'b1; end
        if (k == 1 && qr1.size() > 0 && qr1[0].cyc == cyc) begin r = qr1.pop_front(); have = 1'b1; end
        check_r(k, have, r);
      end
    end
  end

  initial begin
    logic [1:0]  hold;
    logic [1:0]  nr, nw, nl;
    logic [4:0]  na [2];
    logic [31:0] nd [2];
    rq = 2'b00; wq = 2'b00; lq = 2'b00;
    aq[0] = 5'd0; aq[1] = 5'd0; dq[0] = 32'd0; dq[1] = 32'd0;
    model_reset();
    #12;
    chk_reset("rst_init");
    @(posedge clk);
    #2;
    rst = 1'b0;

    // write then read back on port 0
    drive(1'b1, 1'b1, 1'b0, 5'd3, 32'd42, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd3, 32'd0,  1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    idle();
    // both ports read continuously: alternation vs fixed priority
    for (int i = 0; i < 6; i++)
      drive(1'b1, 1'b0, 1'b0, 5'(i), 32'd0, 1'b1, 1'b0, 1'b0, 5'(i + 10), 32'd0);
    idle();
    // port 0 locks, idles two cycles, releases; port 1 waits
    drive(1'b1, 1'b0, 1'b1, 5'd7, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0,  32'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd12, 32'd0);
    drive(1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd12, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd12, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd12, 32'd0);
    idle();
    // top address, cross-port readback
    drive(1'b1, 1'b1, 1'b0, 5'd31, 32'd93, 1'b0, 1'b0, 1'b0, 5'd0,  32'd0);
    drive(1'b0, 1'b0, 1'b0, 5'd0,  32'd0,  1'b1, 1'b0, 1'b0, 5'd31, 32'd0);
    idle();
    // async reset while port 1 holds the lock with a read return in flight
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd2, 32'd0, 1'b1, 1'b0, 1'b1, 5'd6, 32'd0);
    async_reset();
    drive(1'b1, 1'b0, 1'b0, 5'd4, 32'd0, 1'b1, 1'b0, 1'b0, 5'd7, 32'd0);
    idle();

    // random traffic; an ungranted request is held stable
    hold = 2'b00;
    nr = 2'b00; nw = 2'b00; nl = 2'b00;
    na[0] = 5'd0; na[1] = 5'd0; nd[0] = 32'd0; nd[1] = 32'd0;
    for (int i = 0; i < 600; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!hold[n]) begin
          nr[n] = ($urandom_range(0, 3) != 0);
          nw[n] = $urandom_range(0, 1) == 1;
          na[n] = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
          nd[n] = $urandom;
        end
        nl[n] = ($urandom_range(0, 3) == 0);
      end
      drive(nr[0], nw[0], nl[0], na[0], nd[0], nr[1], nw[1], nl[1], na[1], nd[1]);
      for (int n = 0; n < 2; n++)
        hold[n] = rq[n] && (gv[0] != n || gv[1] != n);
    end
    idle();
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
